// File: rtl/mcu_buffer.sv
// mcu_buffer: raster-to-MCU reorder buffer for the JPEG FDCT front end.
// Collects BLK raster rows into a stripe bank, then drains that stripe as
// BLK x BLK blocks, one block row of BLK pixels per output word. Two stripe
// banks ping-pong so the writer keeps filling one while the other drains.
//
// Ports
//   clk, nrst          clock (rising edge), synchronous active-low reset
//   din/din_valid/din_ready      raster pixel input, ready/valid
//   dout/dout_valid/dout_ready   block-row output (dout[0] = leftmost column)
//   dout_first         word is row 0 of a block
//   dout_last          word is row BLK-1 of a block
//   dout_stripe_last   final word of the stripe

// One pixel column of the block row: assembly slot on the write side and the
// output register on the read side.
module mcu_buffer_lane #(
  parameter int DATA_W      = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] pix,
  input  logic              cap,
  output logic [DATA_W-1:0] wr_pix,
  input  logic [DATA_W-1:0] rd_pix,
  input  logic              load,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] pix_s;
  logic [DATA_W-1:0] held;

  // Shift is applied once on the way into the bank, so the stored word is
  // already in output form. MSB inversion == pix - 2^(DATA_W-1) in 2's comp.
  always_comb begin
    pix_s = pix;
    if (LEVEL_SHIFT != 0) pix_s[DATA_W-1] = ~pix[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (cap) held <= pix_s;
  end

  // The completing lane bypasses its slot so the word is written on the same
  // edge its last pixel is accepted.
  assign wr_pix = cap ? pix_s : held;

  always_ff @(posedge clk) begin
    if (!nrst)     dout <= '0;
    else if (load) dout <= rd_pix;
  end
endmodule

module mcu_buffer #(
  parameter int DATA_W      = 8,
  parameter int IMG_WIDTH   = 128,
  parameter int BLK         = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [BLK-1:0][DATA_W-1:0]  dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_first,
  output logic                        dout_last,
  output logic                        dout_stripe_last
);
  localparam int NB = IMG_WIDTH / BLK;
  localparam int RW = $clog2(BLK);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = 1 + RW + BW;
  localparam logic [RW-1:0] R_LAST = RW'(BLK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  typedef struct packed {
    logic first;
    logic last;
    logic stripe_last;
  } flags_t;

  // ---------------- write side ----------------
  logic [RW-1:0] wr_lane, wr_row;
  logic [BW-1:0] wr_blk;
  logic          wr_bank;
  logic [1:0]    full, full_n;
  logic          accept, wr_en, wr_done;
  logic [BLK-1:0]             cap;
  logic [BLK-1:0][DATA_W-1:0] wr_word, rd_word;

  // ---------------- read side -----------------
  state_t        state, state_n;
  logic [RW-1:0] rd_row;
  logic [BW-1:0] rd_blk;
  logic          rd_bank, rd_sel;
  logic          issue, rel, out_free, rd_end;
  flags_t        flg, flg_n;

  assign din_ready = nrst && !full[wr_bank];
  assign accept    = din_valid && din_ready;
  assign wr_en     = accept && (wr_lane == R_LAST);
  assign wr_done   = wr_en && (wr_blk == B_LAST) && (wr_row == R_LAST);

  for (genvar i = 0; i < BLK; i++) begin : g_lane
    assign cap[i] = accept && (wr_lane == RW'(i));
    mcu_buffer_lane #(
      .DATA_W      (DATA_W),
      .LEVEL_SHIFT (LEVEL_SHIFT)
    ) u_lane (
      .clk    (clk),
      .nrst   (nrst),
      .pix    (din),
      .cap    (cap[i]),
      .wr_pix (wr_word[i]),
      .rd_pix (rd_word[i]),
      .load   (issue),
      .dout   (dout[i])
    );
  end

  // Bank storage, addressed {bank, row, block}. The read data is captured by
  // the lane output registers, which makes this a synchronous-read RAM.
  logic [BLK-1:0][DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_row, wr_blk}] <= wr_word;
  end

  assign rd_word = mem[{rd_sel, rd_row, rd_blk}];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_lane <= '0;
      wr_blk  <= '0;
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_lane <= wr_lane + RW'(1);           // BLK is a power of two
      if (wr_lane == R_LAST) begin
        wr_blk <= (wr_blk == B_LAST) ? '0 : wr_blk + BW'(1);
        if (wr_blk == B_LAST) begin
          wr_row <= wr_row + RW'(1);
          if (wr_row == R_LAST) wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Set and clear always hit different banks: the writer only fills an empty
  // bank, the reader only releases a full one.
  always_comb begin
    full_n = full;
    if (rel)     full_n[rd_bank] = 1'b0;
    if (wr_done) full_n[wr_bank] = 1'b1;
  end

  // ---------------- read FSM ----------------
  assign rd_end   = (rd_row == R_LAST) && (rd_blk == B_LAST);
  assign out_free = !dout_valid || dout_ready;

  always_comb begin
    flg_n.first       = (rd_row == '0);
    flg_n.last        = (rd_row == R_LAST);
    flg_n.stripe_last = rd_end;
  end

  // DRAIN waits for the stripe-last word to actually transfer before the bank
  // is released; if the other bank is already full its first word is issued
  // on that same edge so there is no bubble between stripes.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    rel     = 1'b0;
    rd_sel  = rd_bank;
    unique case (state)
      IDLE:  if (full[rd_bank]) state_n = READ;
      READ:  if (out_free) begin
               issue = 1'b1;
               if (rd_end) state_n = DRAIN;
             end
      DRAIN: if (dout_ready) begin
               rel = 1'b1;
               if (full[~rd_bank]) begin
                 issue   = 1'b1;
                 rd_sel  = ~rd_bank;
                 state_n = READ;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      rd_row     <= '0;
      rd_blk     <= '0;
      rd_bank    <= 1'b0;
      full       <= '0;
      dout_valid <= 1'b0;
      flg        <= '0;
    end else begin
      state <= state_n;
      full  <= full_n;
      if (rel) rd_bank <= ~rd_bank;
      if (issue) begin
        flg    <= flg_n;
        rd_row <= rd_row + RW'(1);
        if (rd_row == R_LAST) rd_blk <= (rd_blk == B_LAST) ? '0 : rd_blk + BW'(1);
      end
      dout_valid <= issue || (dout_valid && !dout_ready);
    end
  end

  assign dout_first       = flg.first;
  assign dout_last        = flg.last;
  assign dout_stripe_last = flg.stripe_last;
endmodule

// File: tb/tb_mcu_buffer.sv
// tb_mcu_buffer: three mcu_buffer instances on shared stimulus
//   0: IMG_WIDTH=16,  LEVEL_SHIFT=0
//   1: IMG_WIDTH=16,  LEVEL_SHIFT=1
//   2: IMG_WIDTH=128, LEVEL_SHIFT=1 (defaults)
// Each instance has its own reference model: accepted pixels are collected
// into stripes, a finished stripe is expanded into the expected block-row
// words, and pending full stripes predict din_ready.
module tb_mcu_buffer;
  typedef struct packed {
    logic [7:0][7:0] data;
    logic            first;
    logic            last;
    logic            sl;
  } word_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic [7:0]      din;
  logic            din_valid;
  logic            dout_ready;
  int              rdy_mode;
  logic            drdy [3];
  logic            dv   [3];
  logic            df   [3];
  logic            dl   [3];
  logic            ds   [3];
  logic [7:0][7:0] dq   [3];

  int    checks = 0;
  int    errs   = 0;
  word_t exp_q [3][$];
  logic [7:0] pix_q [3][$];
  int    pend [3];
  int    lat [3];
  int    acc_cnt [3];
  int    out_cnt [3];
  int    lowc [3];
  bit    hold [3];
  word_t hold_w [3];
  logic [63:0] first_w [3];
  logic [63:0] last_w [3];
  bit    rst_edge = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mcu_buffer #(
      .DATA_W      (8),
      .IMG_WIDTH   (g == 2 ? 128 : 16),
      .BLK         (8),
      .LEVEL_SHIFT (g == 0 ? 0 : 1)
    ) u_dut (
      .clk              (clk),
      .nrst             (nrst),
      .din              (din),
      .din_valid        (din_valid),
      .din_ready        (drdy[g]),
      .dout             (dq[g]),
      .dout_valid       (dv[g]),
      .dout_ready       (dout_ready),
      .dout_first       (df[g]),
      .dout_last        (dl[g]),
      .dout_stripe_last (ds[g])
    );
  end

  function automatic int wid(input int k);
    return (k == 2) ? 128 : 16;
  endfunction

  function automatic bit ls(input int k);
    return k != 0;
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Consumer ready pattern: 0 always, 1 toggle, 2 random, 3 held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ~dout_ready;
      2:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  // Monitor + model, sampled mid-cycle; decides what the next edge transfers.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      automatic word_t w;
      automatic word_t cur;
      automatic int    wd = wid(k);
      cur = {dq[k], df[k], dl[k], ds[k]};
      if (rst_edge) begin
        chk($sformatf("rst_dv%0d", k), dv[k], 0);
        chk($sformatf("rst_flags%0d", k), {df[k], dl[k], ds[k]}, 0);
        chk($sformatf("rst_dout%0d", k), dq[k], 0);
      end
      if (!nrst) chk($sformatf("rdy_in_rst%0d", k), drdy[k], 0);
      else       chk($sformatf("din_ready%0d", k), drdy[k], pend[k] < 2);
      if (nrst && !drdy[k]) lowc[k]++;
      if (hold[k]) begin
        chk($sformatf("stall_dv%0d", k), dv[k], 1);
        chk($sformatf("stall_word%0d", k), cur, hold_w[k]);
      end
      if (lat[k] == 3 || lat[k] == 2) chk($sformatf("lat_early%0d", k), dv[k], 0);
      else if (lat[k] == 1)           chk($sformatf("lat_e2_%0d", k), dv[k], 1);
      if (lat[k] > 0) lat[k]--;
      if (exp_q[k].size() == 0) chk($sformatf("dv_idle%0d", k), dv[k], 0);
      hold[k] = 1'b0;
      if (dv[k] && exp_q[k].size() != 0) begin
        if (dout_ready) begin
          w = exp_q[k].pop_front();
          chk($sformatf("word%0d_%0d", k, out_cnt[k]), cur, w);
          if (out_cnt[k] == 0) first_w[k] = dq[k];
          last_w[k] = dq[k];
          out_cnt[k]++;
          if (w.sl) pend[k]--;
        end else begin
          hold[k]   = 1'b1;
          hold_w[k] = cur;
        end
      end
      if (nrst && din_valid && drdy[k]) begin
        acc_cnt[k]++;
        pix_q[k].push_back(din);
        if (pix_q[k].size() == 8 * wd) begin
          if (exp_q[k].size() == 0) lat[k] = 3;
          for (int b = 0; b < wd / 8; b++) begin
            for (int r = 0; r < 8; r++) begin
              for (int j = 0; j < 8; j++)
                w.data[j] = pix_q[k][r * wd + b * 8 + j] ^ (ls(k) ? 8'h80 : 8'h00);
              w.first = (r == 0);
              w.last  = (r == 7);
              w.sl    = (b == wd / 8 - 1) && (r == 7);
              exp_q[k].push_back(w);
            end
          end
          pix_q[k].delete();
          pend[k]++;
        end
      end
      if (!nrst) begin
        pix_q[k].delete();
        exp_q[k].delete();
        pend[k] = 0; lat[k] = 0; acc_cnt[k] = 0; out_cnt[k] = 0; lowc[k] = 0;
        hold[k] = 1'b0;
        first_w[k] = 'x;
        last_w[k]  = 'x;
      end
    end
    rst_edge = !nrst;
  end

  task automatic do_reset();
    nrst = 1'b0;
    din_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  // Sends n pixels as counted by instance 0's handshake.
  task automatic send(input int n, input int base, input int step, input bit gaps, input bit rnd);
    int i = 0;
    int t = 0;
    while (i < n && t < 40000) begin
      din       = rnd ? 8'($urandom) : 8'(base + step * i);
      din_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (din_valid && drdy[0]) i++;
      @(posedge clk); #1;
      t++;
    end
    din_valid = 1'b0;
    chk("send_count", i, n);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_in_time", t < 20000, 1);
  endtask

  initial begin
    nrst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1; rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // row ordering
    send(128, 0, 1, 0, 0);
    drain();
    chk("ro_first", first_w[0], 64'h0706050403020100);
    chk("ro_cnt", out_cnt[0], 16);
    chk("ro_wide_cnt", out_cnt[2], 0);

    // backpressure, ready toggling
    do_reset();
    rdy_mode = 1;
    send(128, 0, 1, 0, 0);
    drain();
    rdy_mode = 0;
    chk("bp_cnt", out_cnt[0], 16);
    chk("bp_first", first_w[0], 64'h0706050403020100);
    chk("bp_last", last_w[0], 64'h7f7e7d7c7b7a7978);

    // level shift
    do_reset();
    send(128, 0, 0, 0, 0);
    send(128, 255, 0, 0, 0);
    drain();
    chk("ls_first", first_w[1], 64'h8080808080808080);
    chk("ls_last", last_w[1], 64'h7f7f7f7f7f7f7f7f);
    chk("ls_cnt", out_cnt[1], 32);

    // ping-pong full
    do_reset();
    rdy_mode = 3;
    repeat (400) begin
      din = 8'($urandom); din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    chk("pp_acc", acc_cnt[0], 256);
    chk("pp_rdy", drdy[0], 0);
    rdy_mode = 0;
    send(128, 0, 0, 0, 1);
    drain();
    chk("pp_cnt", out_cnt[0], 48);

    // mid-stream reset
    do_reset();
    send(70, 0, 1, 0, 0);
    do_reset();
    send(128, 200, 1, 0, 0);
    drain();
    chk("mr_first", first_w[0], 64'hcfcecdcccbcac9c8);
    chk("mr_cnt", out_cnt[0], 16);

    // random data, random gaps and random consumer
    do_reset();
    rdy_mode = 2;
    send(512, 0, 0, 1, 1);
    drain();
    rdy_mode = 0;
    chk("rnd_cnt0", out_cnt[0], 64);
    chk("rnd_cnt1", out_cnt[1], 64);

    // default-size image
    do_reset();
    send(16384, 0, 1, 0, 0);
    drain();
    chk("def_cnt", out_cnt[2], 2048);
    chk("def_first", first_w[2], 64'h8786858483828180);
    chk("def_rdy_low", lowc[2], 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
